mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch / data) onto a single shared memory bus.
// Data has priority; a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              ibus_req,
    input  logic [XLEN-1:0]   ibus_addr,
    output logic              ibus_ready,
    output logic              ibus_rvalid,
    output logic [XLEN-1:0]   ibus_rdata,
    input  logic              ibus_flush,
    input  logic              dbus_req,
    input  logic              dbus_write,
    input  logic [XLEN-1:0]   dbus_addr,
    input  logic [XLEN-1:0]   dbus_wdata,
    input  logic [XLEN/8-1:0] dbus_wstrb,
    output logic              dbus_ready,
    output logic              dbus_rvalid,
    output logic [XLEN-1:0]   dbus_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       discard, discard_nxt;
    logic       free, sel_i, grant, i_acc, d_acc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            starve_cnt <= '0;
            discard    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            discard    <= discard_nxt;
        end
    end

    always_comb begin
        // The slot frees up in the same cycle the outstanding read returns.
        free  = (state == IDLE) ||
                (((state == I_WAIT) || (state == D_WAIT)) && bus_rvalid);
        sel_i = ibus_req && (!dbus_req || (starve_cnt == LIMIT));
        // Gating with rst_b keeps every output low while reset is held.
        grant = rst_b && free && (ibus_req || dbus_req);
        i_acc = grant && sel_i && bus_ready;
        d_acc = grant && !sel_i && bus_ready;

        bus_req   = grant;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        if (grant) begin
            if (sel_i) begin
                bus_addr = ibus_addr;
            end else begin
                bus_write = dbus_write;
                bus_addr  = dbus_addr;
                bus_wdata = dbus_wdata;
                bus_wstrb = dbus_wstrb;
            end
        end

        ibus_ready  = i_acc;
        dbus_ready  = d_acc;
        ibus_rvalid = rst_b && (state == I_WAIT) && bus_rvalid && !discard && !ibus_flush;
        ibus_rdata  = ibus_rvalid ? bus_rdata : '0;
        dbus_rvalid = rst_b && (state == D_WAIT) && bus_rvalid;
        dbus_rdata  = dbus_rvalid ? bus_rdata : '0;

        state_nxt = state;
        if (free) begin
            if (i_acc)                    state_nxt = I_WAIT;
            else if (d_acc && !dbus_write) state_nxt = D_WAIT;
            else                          state_nxt = IDLE;
        end

        // Response clears the flag; a fetch accepted alongside a flush re-arms it.
        discard_nxt = discard;
        if ((state == I_WAIT) && bus_rvalid)      discard_nxt = 1'b0;
        else if ((state == I_WAIT) && ibus_flush) discard_nxt = 1'b1;
        if (i_acc && ibus_flush)                  discard_nxt = 1'b1;

        starve_nxt = starve_cnt;
        if (!ibus_req || i_acc)               starve_nxt = '0;
        else if (d_acc && starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
    end

endmodule
